flp_relu_pipe: RTL and testbench

FLP_RELU_PIPE -- requirements
Module: flp_relu_pipe

---
 rtl/flp_relu_pkg.sv | 35 +++
 rtl/flp_relu_lane.sv | 55 +++++
 rtl/flp_relu_pipe.sv | 167 ++++++++++++++++
 tb/tb_flp_relu_pipe.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flp_relu_pkg.sv
// Shared definitions for the packed-lane floating-point ReLU pipeline:
// lane-width helpers, packed-lane index functions and the S1 payload struct.
package flp_relu_pkg;

    // Bit width of one IEEE-style lane for the default 8/23 format.
    localparam int LANE_W_DFLT = 32;

    // The S1 payload is sized for the largest supported beat. The top only
    // ever writes the low LANES*W value bits and EWIDTH-1 shift bits; the
    // remaining bits stay zero and fall away in synthesis.
    localparam int PAY_V_MAX = 2048;
    localparam int PAY_E_MAX = 16;

    // Width of one lane word: sign + exponent + stored significand.
    function automatic int lane_w(input int ewidth, input int swidth);
        return 1 + ewidth + swidth;
    endfunction

    // Lowest bit of a lane inside a packed vector (lane 0 in the LSBs).
    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

    // Highest bit of a lane inside a packed vector.
    function automatic int lane_hi(input int lane, input int w);
        return lane * w + w - 1;
    endfunction

    typedef struct packed {
        logic [PAY_V_MAX-1:0] v;   // packed lane values
        logic                 l;   // leaky mode
        logic [PAY_E_MAX-1:0] e;   // leaky shift
    } s1_pay_t;

endpackage

// File: rtl/flp_relu_lane.sv
// One lane of the floating-point ReLU / leaky ReLU. Purely combinational;
// sits between the S1 and S2 registers of flp_relu_pipe.
module flp_relu_lane
    import flp_relu_pkg::*;
#(
    parameter int EWIDTH = 8,
    parameter int SWIDTH = 23
) (
    input  logic [EWIDTH+SWIDTH:0] x,
    input  logic                   leaky,
    input  logic [EWIDTH-2:0]      shift,
    output logic [EWIDTH+SWIDTH:0] y,
    output logic                   uflow
);

    localparam int W = lane_w(EWIDTH, SWIDTH);

    logic              sgn;
    logic [EWIDTH-1:0] ex;
    logic [SWIDTH-1:0] man;
    logic [EWIDTH-1:0] shift_x;
    logic [EWIDTH-1:0] ex_dec;
    logic              ex_max;
    logic              is_nan;

    assign sgn     = x[W-1];
    assign ex      = x[W-2:SWIDTH];
    assign man     = x[SWIDTH-1:0];
    assign shift_x = {1'b0, shift};
    assign ex_dec  = ex - shift_x;
    assign ex_max  = &ex;
    assign is_nan  = ex_max && (|man);

    // Select the lane result; only negative non-NaN inputs are modified.
    // ex_dec cannot wrap because the flush branch catches ex <= shift first.
    always_comb begin
        y     = x;
        uflow = 1'b0;
        if (sgn && !is_nan) begin
            if (!leaky) begin
                y = '0;
            end else if (shift == '0) begin
                y = x;
            end else if (ex_max) begin
                y = x;                       // -Inf stays -Inf
            end else if (ex <= shift_x) begin
                y     = '0;                  // flush-to-zero, covers -0 and denormals
                uflow = 1'b1;
            end else begin
                y = {sgn, ex_dec, man};
            end
        end
    end

endmodule

// File: rtl/flp_relu_pipe.sv
// Two-stage packed-lane floating-point ReLU / leaky ReLU with valid/ready
// handshake on both sides and a synchronous flush.
// Optional feature: define FLP_RELU_PIPE_UFLOW_CNT_EN to add o_uflow_cnt,
// a saturating count of lanes flushed to +0 by the leaky underflow rule.
module flp_relu_pipe
    import flp_relu_pkg::*;
#(
    parameter int EWIDTH = 8,
    parameter int SWIDTH = 23,
    parameter int LANES  = 4
) (
    input  logic                                   clk,
    input  logic                                   nrst,
    input  logic                                   i_vld,
    output logic                                   o_rdy,
    input  logic [LANES*(1+EWIDTH+SWIDTH)-1:0]     i_v,
    input  logic                                   i_l,
    input  logic [EWIDTH-2:0]                      i_e,
    input  logic                                   i_flush,
    output logic                                   o_vld,
    input  logic                                   i_rdy,
    output logic [LANES*(1+EWIDTH+SWIDTH)-1:0]     o_r
`ifdef FLP_RELU_PIPE_UFLOW_CNT_EN
    ,
    output logic [15:0]                            o_uflow_cnt
`endif
);

    localparam int W  = lane_w(EWIDTH, SWIDTH);
    localparam int VW = LANES * W;

    s1_pay_t          pay_in;
    s1_pay_t          pay_p1;
    logic             vld_p1;
    logic             vld_p2;
    logic [VW-1:0]    r_comb;
    logic [VW-1:0]    r_p2;
    logic [LANES-1:0] uf_comb;
    logic             adv1;
    logic             adv2;
    logic             acc;
    logic             unused_pay;

    // S2 moves when empty or handing its beat downstream; S1 moves when
    // empty or when S2 takes its beat. A flush blocks new acceptance.
    assign adv2  = !vld_p2 || i_rdy;
    assign adv1  = !vld_p1 || adv2;
    assign o_rdy = adv1 && !i_flush;
    assign acc   = i_vld && o_rdy;

    // Pack the incoming beat and its mode into the S1 payload.
    always_comb begin
        pay_in                 = '0;
        pay_in.v[VW-1:0]       = i_v;
        pay_in.l               = i_l;
        pay_in.e[EWIDTH-2:0]   = i_e;
    end

    // ---- Stage S1: capture inputs and mode ----
    // S1 valid flag and payload register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_p1 <= 1'b0;
            pay_p1 <= '0;
        end else begin
            if (i_flush) begin
                vld_p1 <= 1'b0;
            end else if (adv1) begin
                vld_p1 <= acc;
            end
            if (acc) begin
                pay_p1 <= pay_in;
            end
        end
    end

    // ---- Combinational lane evaluation between S1 and S2 ----
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        flp_relu_lane #(
            .EWIDTH (EWIDTH),
            .SWIDTH (SWIDTH)
        ) u_lane (
            .x     (pay_p1.v[lane_lo(g, W) +: W]),
            .leaky (pay_p1.l),
            .shift (pay_p1.e[EWIDTH-2:0]),
            .y     (r_comb[lane_lo(g, W) +: W]),
            .uflow (uf_comb[g])
        );
    end

    // Payload bits above the configured beat are constant zero.
    assign unused_pay = ^pay_p1;

    // ---- Stage S2: hold results ----
    // S2 valid flag and result register; held while stalled.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_p2 <= 1'b0;
            r_p2   <= '0;
        end else begin
            if (i_flush) begin
                vld_p2 <= 1'b0;
            end else if (adv2) begin
                vld_p2 <= vld_p1;
            end
            if (adv2 && vld_p1) begin
                r_p2 <= r_comb;
            end
        end
    end

    assign o_vld = vld_p2;
    assign o_r   = r_p2;

`ifdef FLP_RELU_PIPE_UFLOW_CNT_EN
    localparam int CW = $clog2(LANES + 1);

    logic [CW-1:0] uf_n_comb;
    logic [CW-1:0] uf_p2;
    logic [15:0]   uf_cnt;

    // Number of set flags in a lane flag vector.
    function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] bits);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + CW'(bits[i]);
        end
        return n;
    endfunction

    // 16-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CW-1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign uf_n_comb = popcount(uf_comb);

    // Per-beat underflow lane count travelling with the S2 result.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            uf_p2 <= '0;
        end else if (adv2 && vld_p1) begin
            uf_p2 <= uf_n_comb;
        end
    end

    // Accumulate underflow lanes of beats actually handed downstream.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            uf_cnt <= '0;
        end else if (i_flush) begin
            uf_cnt <= '0;
        end else if (vld_p2 && i_rdy) begin
            uf_cnt <= sat_add16(uf_cnt, uf_p2);
        end
    end

    assign o_uflow_cnt = uf_cnt;
`else
    logic unused_uf;
    assign unused_uf = ^uf_comb;
`endif

endmodule

// File: tb/tb_flp_relu_pipe.sv
// Self-checking bench for flp_relu_pipe (default 8/23 format, 4 lanes).
// Honours FLP_RELU_PIPE_UFLOW_CNT_EN when the design is built with it.
module tb_flp_relu_pipe;

    localparam int EW    = 8;
    localparam int SW    = 23;
    localparam int LANES = 4;
    localparam int W     = 1 + EW + SW;
    localparam int VW    = LANES * W;

    logic          clk = 1'b0;
    logic          nrst;
    logic          i_vld;
    logic          o_rdy;
    logic [VW-1:0] i_v;
    logic          i_l;
    logic [EW-2:0] i_e;
    logic          i_flush;
    logic          o_vld;
    logic          i_rdy;
    logic [VW-1:0] o_r;
`ifdef FLP_RELU_PIPE_UFLOW_CNT_EN
    logic [15:0]   o_uflow_cnt;
`endif

    always #5 clk = ~clk;

    flp_relu_pipe #(
        .EWIDTH (EW),
        .SWIDTH (SW),
        .LANES  (LANES)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .i_vld       (i_vld),
        .o_rdy       (o_rdy),
        .i_v         (i_v),
        .i_l         (i_l),
        .i_e         (i_e),
        .i_flush     (i_flush),
        .o_vld       (o_vld),
        .i_rdy       (i_rdy),
        .o_r         (o_r)
`ifdef FLP_RELU_PIPE_UFLOW_CNT_EN
        ,
        .o_uflow_cnt (o_uflow_cnt)
`endif
    );

    typedef struct {
        logic [VW-1:0] r;
        int            acc_edge;
        int            uf;
    } beat_t;

    beat_t q[$];
    int    cyc    = 0;
    int    nvec   = 0;
    int    nerr   = 0;
    int    n_acc  = 0;
    int    uf_cnt = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Reference for one lane, straight from the activation rules.
    function automatic logic [W-1:0] ref_lane(input logic [W-1:0] x, input logic l,
                                              input int e, output int uf);
        int ex;
        int man;
        ex  = int'(x[W-2:SW]);
        man = int'(x[SW-1:0]);
        uf  = 0;
        if (x[W-1] == 1'b0) return x;
        if (ex == (1 << EW) - 1 && man != 0) return x;   // NaN
        if (!l) return '0;
        if (e == 0) return x;
        if (ex == (1 << EW) - 1) return x;               // -Inf
        if (ex <= e) begin
            uf = 1;
            return '0;
        end
        return {1'b1, EW'(ex - e), x[SW-1:0]};
    endfunction

    function automatic logic [VW-1:0] ref_beat(input logic [VW-1:0] v, input logic l,
                                               input logic [EW-2:0] e, output int uf);
        logic [VW-1:0] r;
        int u;
        r  = '0;
        uf = 0;
        for (int k = 0; k < LANES; k++) begin
            r[k*W +: W] = ref_lane(v[k*W +: W], l, int'(e), u);
            uf += u;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_lane();
        case ($urandom_range(0, 6))
            0:       return W'($urandom);
            1:       return {1'b1, EW'($urandom_range(0, 12)), SW'($urandom)};
            2:       return 32'hFF800000;
            3:       return {1'($urandom), {EW{1'b1}}, SW'($urandom | 1)};
            4:       return 32'h80000000;
            5:       return {1'b0, 31'($urandom)};
            default: return {1'b1, EW'($urandom_range(200, 254)), SW'($urandom)};
        endcase
    endfunction

    function automatic logic [VW-1:0] rnd_beat();
        logic [VW-1:0] v;
        for (int k = 0; k < LANES; k++) v[k*W +: W] = rnd_lane();
        return v;
    endfunction

    // One clock: check outputs against the model, drive inputs, check o_rdy,
    // advance the model, then move to the next falling edge.
    task automatic step(input logic vld, input logic [VW-1:0] v, input logic l,
                        input logic [EW-2:0] e, input logic rdy, input logic fl);
        logic  exp_vld;
        logic  exp_rdy;
        beat_t b;
        exp_vld = (q.size() > 0) && (cyc >= q[0].acc_edge + 1);
        check("o_vld", VW'(o_vld), VW'(exp_vld));
        if (exp_vld) check("o_r", o_r, q[0].r);
`ifdef FLP_RELU_PIPE_UFLOW_CNT_EN
        check("o_uflow_cnt", VW'(o_uflow_cnt), VW'(uf_cnt));
`endif
        i_vld   = vld;
        i_v     = v;
        i_l     = l;
        i_e     = e;
        i_rdy   = rdy;
        i_flush = fl;
        #1;
        exp_rdy = !fl && (q.size() < 2 || rdy);
        check("o_rdy", VW'(o_rdy), VW'(exp_rdy));
        if (fl) begin
            q.delete();
            uf_cnt = 0;
        end else begin
            if (exp_vld && rdy) begin
                uf_cnt = (uf_cnt + q[0].uf > 65535) ? 65535 : uf_cnt + q[0].uf;
                void'(q.pop_front());
            end
            if (vld && exp_rdy) begin
                b.r        = ref_beat(v, l, e, b.uf);
                b.acc_edge = cyc + 1;
                q.push_back(b);
                n_acc++;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    // Asynchronous reset pulse between clock edges, with immediate checks.
    task automatic pulse_reset();
        i_vld   = 1'b0;
        i_flush = 1'b0;
        i_rdy   = 1'b1;
        #2;
        nrst = 1'b0;
        #1;
        check("rst_o_vld", VW'(o_vld), '0);
        check("rst_o_r", o_r, '0);
        check("rst_o_rdy", VW'(o_rdy), VW'(1'b1));
        q.delete();
        uf_cnt = 0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    logic [VW-1:0] beats [8];
    logic [VW-1:0] v032;
    logic [VW-1:0] v033;
    int            u;
    int            k;
    int            guard;

    initial begin
        nrst    = 1'b0;
        i_vld   = 1'b0;
        i_v     = '0;
        i_l     = 1'b0;
        i_e     = '0;
        i_flush = 1'b0;
        i_rdy   = 1'b1;

        // Hand-computed points that pin the reference model.
        check("pin_plain_neg", VW'(ref_lane(32'hBF800000, 1'b0, 0, u)), VW'(32'h00000000));
        check("pin_plain_nan", VW'(ref_lane(32'h7FC00000, 1'b0, 0, u)), VW'(32'h7FC00000));
        check("pin_leaky_m4", VW'(ref_lane(32'hC0800000, 1'b1, 2, u)), VW'(32'hBF800000));
        check("pin_leaky_uf", VW'(ref_lane(32'h80800000, 1'b1, 2, u)), VW'(32'h00000000));
        check("pin_leaky_uf_flag", VW'(u), VW'(1));
        check("pin_leaky_ninf", VW'(ref_lane(32'hFF800000, 1'b1, 5, u)), VW'(32'hFF800000));

        // Reset state while nrst is held low.
        repeat (2) @(negedge clk);
        #1;
        check("reset_o_vld", VW'(o_vld), '0);
        check("reset_o_rdy", VW'(o_rdy), VW'(1'b1));
        check("reset_o_r", o_r, '0);
        @(negedge clk);
        nrst = 1'b1;
        idle(2);

        // Plain ReLU on the four reference lanes, literal result after 2 cycles.
        v032 = {32'h80000000, 32'h7FC00000, 32'hBF800000, 32'h3F800000};
        step(1'b1, v032, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        check("req032_vld", VW'(o_vld), VW'(1'b1));
        check("req032_r", o_r, {32'h00000000, 32'h7FC00000, 32'h00000000, 32'h3F800000});
        idle(2);

        // Leaky with shift 2: -4.0 -> -1.0, exponent-1 lane flushed.
        v033 = {32'h00000000, 32'h00000000, 32'h80800000, 32'hC0800000};
        step(1'b1, v033, 1'b1, 7'd2, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        check("req033_r", o_r, {32'h00000000, 32'h00000000, 32'h00000000, 32'hBF800000});
        idle(2);

        // Eight back-to-back beats while downstream ready toggles 1,0,0,...
        for (int i = 0; i < 8; i++) beats[i] = rnd_beat();
        k     = n_acc;
        guard = 0;
        while (n_acc - k < 8 && guard < 80) begin
            step(1'b1, beats[n_acc - k], 1'($urandom), 7'($urandom_range(0, 9)),
                 (guard % 3) == 0, 1'b0);
            guard++;
        end
        if (n_acc - k < 8) check("req034_accept_timeout", VW'(n_acc - k), VW'(8));
        for (int i = 0; i < 9; i++) step(1'b0, '0, 1'b0, '0, (i % 3) == 0, 1'b0);
        idle(3);

        // Fill the pipe under back-pressure, then flush for one cycle.
        step(1'b1, rnd_beat(), 1'b1, 7'd3, 1'b0, 1'b0);
        step(1'b1, rnd_beat(), 1'b0, 7'd0, 1'b0, 1'b0);
        step(1'b1, rnd_beat(), 1'b1, 7'd1, 1'b0, 1'b0);
        step(1'b1, rnd_beat(), 1'b1, 7'd1, 1'b0, 1'b1);
        idle(4);

        // Reset with two beats in flight, then a fresh beat.
        step(1'b1, rnd_beat(), 1'b1, 7'd4, 1'b0, 1'b0);
        step(1'b1, rnd_beat(), 1'b1, 7'd4, 1'b0, 1'b0);
        pulse_reset();
        step(1'b1, v032, 1'b0, '0, 1'b1, 1'b0);
        idle(4);

        // Random traffic: valid, ready, mode and shift all vary per cycle.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rnd_beat(), 1'($urandom),
                 ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 12)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
